// File: rtl/hps_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hps_reset_pkg
//  Description : Shared types and constants for the HPS reset sequencer.
//                - state_t : sequencer FSM states
//                - grant_t : grant encoding reported on last_grant
//                - default pulse / holdoff lengths and counter width
//                - grant_mask() : grant -> one-hot {debug, warm, cold}
//  Revision    : 1.0 - initial release
// ============================================================================
package hps_reset_pkg;

    localparam int c_cnt_w = 8;

    localparam int unsigned c_cold_len_default  = 6;
    localparam int unsigned c_warm_len_default  = 2;
    localparam int unsigned c_debug_len_default = 32;
    localparam int unsigned c_holdoff_default   = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PULSE      = 2'd1,
        ST_HOLDOFF    = 2'd2,
        ST_WAIT_READY = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_COLD  = 2'd1,
        GRANT_WARM  = 2'd2,
        GRANT_DEBUG = 2'd3
    } grant_t;

    // One-hot position of a grant in the {debug, warm, cold} request vector.
    function automatic logic [2:0] grant_mask(input grant_t g);
        logic [2:0] m;
        m = 3'b000;
        case (g)
            GRANT_COLD:  m = 3'b001;
            GRANT_WARM:  m = 3'b010;
            GRANT_DEBUG: m = 3'b100;
            default:     m = 3'b000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_pulse_timer
//  Description : Loadable down-counter that parks at zero.
//  Ports       : clk        - clock (rising edge)
//                rst        - synchronous active-high reset (count -> 0)
//                load       - load load_value this cycle
//                load_value - value to load
//                value      - current count
//                done       - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_pulse_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Counts down to zero and stays there until the next load; never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - c_one;
        end
    end

    assign value = r_count;
    assign done  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/hps_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hps_reset_sequencer
//  Description : Serialises cold / warm / debug reset requests to the HPS.
//                Request rising edges are latched as pending bits and served
//                one at a time (cold > warm > debug): an active-low pulse of
//                the granted length, a quiet holdoff, then (cold/warm only)
//                a wait for the HPS to come back out of reset.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                req_cold/warm/debug  - level requests (edge-detected)
//                hps_ready            - 1 = HPS out of reset
//                cold/warm/debug_reset_n - registered active-low pulses
//                busy                 - sequencer not idle
//                pending              - latched requests {debug, warm, cold}
//                last_grant           - 0 none, 1 cold, 2 warm, 3 debug
//  Revision    : 1.0 - initial release
// ============================================================================
module hps_reset_sequencer
    import hps_reset_pkg::*;
#(
    parameter int unsigned COLD_LEN  = c_cold_len_default,
    parameter int unsigned WARM_LEN  = c_warm_len_default,
    parameter int unsigned DEBUG_LEN = c_debug_len_default,
    parameter int unsigned HOLDOFF   = c_holdoff_default
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_cold,
    input  logic       req_warm,
    input  logic       req_debug,
    input  logic       hps_ready,
    output logic       cold_reset_n,
    output logic       warm_reset_n,
    output logic       debug_reset_n,
    output logic       busy,
    output logic [2:0] pending,
    output logic [1:0] last_grant
);

    // The counter is loaded with LEN-1 so that a value of 0 marks the last
    // cycle of the phase, giving exactly LEN cycles per phase.
    localparam logic [c_cnt_w-1:0] c_cold_load    = c_cnt_w'(COLD_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_warm_load    = c_cnt_w'(WARM_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_debug_load   = c_cnt_w'(DEBUG_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_holdoff_load = c_cnt_w'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic               c_has_holdoff  = (HOLDOFF != 0);

    state_t             r_state, w_state_next, w_after_holdoff;
    grant_t             r_grant, w_grant_next;
    logic [2:0]         r_prev;
    logic [2:0]         w_req;
    logic [2:0]         w_edge;
    logic [2:0]         r_pending, w_pending_next;
    logic [2:0]         r_rst_n, w_rst_n_next;
    logic               r_busy;
    logic               w_load;
    logic [c_cnt_w-1:0] w_load_value;
    logic [c_cnt_w-1:0] w_count;
    logic               w_done;

    assign w_req  = {req_debug, req_warm, req_cold};
    assign w_edge = w_req & ~r_prev;

    // Debug resets do not take the HPS out of its running state, so there is
    // nothing to wait for afterwards.
    assign w_after_holdoff = (r_grant == GRANT_DEBUG) ? ST_IDLE : ST_WAIT_READY;

    reset_pulse_timer #(
        .WIDTH      (c_cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .load       (w_load),
        .load_value (w_load_value),
        .value      (w_count),
        .done       (w_done)
    );

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_pending_next = r_pending | w_edge;
        w_load         = 1'b0;
        w_load_value   = '0;
        w_rst_n_next   = 3'b111;

        case (r_state)
            ST_IDLE: begin
                // Grant only with the timer parked so a new phase never
                // inherits a stale count.
                if ((r_pending != 3'b000) && (w_count == '0)) begin
                    w_state_next = ST_PULSE;
                    w_load       = 1'b1;
                    if (r_pending[0]) begin
                        // A cold reset supersedes everything, including
                        // edges arriving in this very cycle.
                        w_grant_next   = GRANT_COLD;
                        w_load_value   = c_cold_load;
                        w_pending_next = 3'b000;
                    end else if (r_pending[1]) begin
                        w_grant_next   = GRANT_WARM;
                        w_load_value   = c_warm_load;
                        w_pending_next = (r_pending & 3'b101) | w_edge;
                    end else begin
                        w_grant_next   = GRANT_DEBUG;
                        w_load_value   = c_debug_load;
                        w_pending_next = (r_pending & 3'b011) | w_edge;
                    end
                end
            end
            ST_PULSE: begin
                if (w_done) begin
                    if (c_has_holdoff) begin
                        w_state_next = ST_HOLDOFF;
                        w_load       = 1'b1;
                        w_load_value = c_holdoff_load;
                    end else begin
                        w_state_next = w_after_holdoff;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (w_done) begin
                    w_state_next = w_after_holdoff;
                end
            end
            ST_WAIT_READY: begin
                if (hps_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the pulse starts the
        // cycle right after the grant.
        if (w_state_next == ST_PULSE) begin
            w_rst_n_next = ~grant_mask(w_grant_next);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= GRANT_NONE;
            r_prev    <= 3'b111;   // a request held through reset is not an edge
            r_pending <= 3'b000;
            r_rst_n   <= 3'b111;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_prev    <= w_req;
            r_pending <= w_pending_next;
            r_rst_n   <= w_rst_n_next;
            r_busy    <= (w_state_next != ST_IDLE);
        end
    end

    assign cold_reset_n  = r_rst_n[0];
    assign warm_reset_n  = r_rst_n[1];
    assign debug_reset_n = r_rst_n[2];
    assign busy          = r_busy;
    assign pending       = r_pending;
    assign last_grant    = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_hps_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hps_reset_sequencer
//  Description : Self-checking bench for hps_reset_sequencer. A timeline
//                reference model (grant edge, release edge, pending set)
//                predicts every output after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hps_reset_sequencer;

    localparam int LEN_COLD  = 6;
    localparam int LEN_WARM  = 2;
    localparam int LEN_DEBUG = 32;
    localparam int HOLD      = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_cold, req_warm, req_debug;
    logic       hps_ready;
    logic       cold_reset_n, warm_reset_n, debug_reset_n;
    logic       busy;
    logic [2:0] pending;
    logic [1:0] last_grant;

    int n_checks = 0;
    int n_errors = 0;

    hps_reset_sequencer #(
        .COLD_LEN      (LEN_COLD),
        .WARM_LEN      (LEN_WARM),
        .DEBUG_LEN     (LEN_DEBUG),
        .HOLDOFF       (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_cold      (req_cold),
        .req_warm      (req_warm),
        .req_debug     (req_debug),
        .hps_ready     (hps_ready),
        .cold_reset_n  (cold_reset_n),
        .warm_reset_n  (warm_reset_n),
        .debug_reset_n (debug_reset_n),
        .busy          (busy),
        .pending       (pending),
        .last_grant    (last_grant)
    );

    always #10 clk = ~clk;

    // ---------------- reference model (timeline based) ----------------
    // type: 1 cold, 2 warm, 3 debug. A job granted at edge g holds its
    // reset low after edges g .. g+len-1; holdoff ends at edge rel=g+len+HOLD.
    // Debug jobs finish at edge rel; cold/warm finish at the first edge
    // after rel that samples hps_ready=1.
    int       m_edge = 0;
    bit [2:0] m_prev = 3'b111;
    bit [2:0] m_pend = 3'b000;
    bit       m_job  = 1'b0;
    int       m_type = 0;
    int       m_last = 0;
    int       m_g    = 0;
    int       m_rel  = 0;

    function automatic int len_of(input int t);
        if (t == 1) return LEN_COLD;
        if (t == 2) return LEN_WARM;
        return LEN_DEBUG;
    endfunction

    task automatic model_step(input bit rst_v, input bit [2:0] req_v, input bit rdy_v);
        bit [2:0] e;
        m_edge++;
        if (rst_v) begin
            m_prev = 3'b111;
            m_pend = 3'b000;
            m_job  = 1'b0;
            m_last = 0;
        end else begin
            e      = req_v & ~m_prev;
            m_prev = req_v;
            if (!m_job) begin
                if (m_pend != 3'b000) begin
                    m_type = m_pend[0] ? 1 : (m_pend[1] ? 2 : 3);
                    m_last = m_type;
                    m_job  = 1'b1;
                    m_g    = m_edge;
                    m_rel  = m_edge + len_of(m_type) + HOLD;
                    if (m_type == 1) begin
                        m_pend = 3'b000;
                    end else begin
                        m_pend[m_type-1] = 1'b0;
                        m_pend = m_pend | e;
                    end
                end else begin
                    m_pend = m_pend | e;
                end
            end else begin
                m_pend = m_pend | e;
                if (m_type == 3) begin
                    if (m_edge == m_rel) m_job = 1'b0;
                end else begin
                    if (m_edge > m_rel && rdy_v) m_job = 1'b0;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, m_edge, $time);
        end
    endtask

    task automatic tick(input bit rst_v, input bit [2:0] req_v, input bit rdy_v);
        bit [2:0] exp_rstn;
        reset     = rst_v;
        req_cold  = req_v[0];
        req_warm  = req_v[1];
        req_debug = req_v[2];
        hps_ready = rdy_v;
        @(posedge clk);
        model_step(rst_v, req_v, rdy_v);
        #1;
        exp_rstn = 3'b111;
        if (m_job && (m_edge < m_g + len_of(m_type))) exp_rstn[m_type-1] = 1'b0;
        check_value("cold_reset_n",  {7'd0, cold_reset_n},  {7'd0, exp_rstn[0]});
        check_value("warm_reset_n",  {7'd0, warm_reset_n},  {7'd0, exp_rstn[1]});
        check_value("debug_reset_n", {7'd0, debug_reset_n}, {7'd0, exp_rstn[2]});
        check_value("busy",          {7'd0, busy},          {7'd0, m_job});
        check_value("pending",       {5'd0, pending},       {5'd0, m_pend});
        check_value("last_grant",    {6'd0, last_grant},    8'(m_last));
    endtask

    task automatic run(input int n, input bit [2:0] req_v, input bit rdy_v);
        for (int i = 0; i < n; i++) tick(1'b0, req_v, rdy_v);
    endtask

    initial begin
        reset     = 1'b1;
        req_cold  = 1'b0;
        req_warm  = 1'b0;
        req_debug = 1'b0;
        hps_ready = 1'b1;

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b1, 3'b000, 1'b1);
        run(3, 3'b000, 1'b1);

        // Single warm edge, HPS ready
        run(4, 3'b010, 1'b1);
        run(30, 3'b000, 1'b1);

        // Warm and debug rising together: warm first, debug after
        run(2, 3'b110, 1'b1);
        run(90, 3'b000, 1'b1);

        // Cold during a debug pulse with warm also pending
        run(1, 3'b100, 1'b1);
        run(5, 3'b000, 1'b1);
        run(1, 3'b010, 1'b1);
        run(3, 3'b000, 1'b1);
        run(1, 3'b001, 1'b1);
        run(80, 3'b000, 1'b1);

        // Cold pulse then HPS held in reset for a long time
        run(1, 3'b001, 1'b0);
        run(LEN_COLD + HOLD + 45, 3'b000, 1'b0);
        run(5, 3'b000, 1'b1);

        // Reset on the 3rd low cycle of a debug pulse, request held high
        run(4, 3'b100, 1'b1);
        tick(1'b1, 3'b100, 1'b1);
        run(60, 3'b100, 1'b1);
        run(5, 3'b000, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit [2:0] r;
            r[0] = ($urandom_range(0, 14) == 0);
            r[1] = ($urandom_range(0, 9) == 0);
            r[2] = ($urandom_range(0, 9) == 0);
            tick(($urandom_range(0, 399) == 0), r, ($urandom_range(0, 3) != 0));
        end
        run(120, 3'b000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hps_reset_sequencer.md
HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

Interface
REQ-001 SHALL have parameter COLD_LEN, default 6: cold reset pulse length in clk cycles (1..255).
REQ-002 SHALL have parameter WARM_LEN, default 2: warm reset pulse length in cycles (1..255).
REQ-003 SHALL have parameter DEBUG_LEN, default 32: debug reset pulse length in cycles (1..255).
REQ-004 SHALL have parameter HOLDOFF, default 16: quiet cycles after every pulse (0..255).
REQ-005 SHALL have port clk, input, 1: single clock (FPGA 50 MHz domain); all logic rising-edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port req_cold / req_warm / req_debug, input, 1 each: level requests, acted on at rising edge.
REQ-008 SHALL have port hps_ready, input, 1: HPS-to-FPGA reset_n, synchronous to clk; 1 = HPS out of reset.
REQ-009 SHALL have port cold_reset_n / warm_reset_n / debug_reset_n, output, 1 each: active-low reset requests to the HPS.
REQ-010 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have port pending, output, 3: latched unserved requests {debug, warm, cold}.
REQ-012 SHALL have port last_grant, output, 2: 0 = none, 1 = cold, 2 = warm, 3 = debug.

Function
REQ-013 SHALL detect a request edge when the input is 1 and its registered previous value is 0; an edge sets the matching pending bit.
REQ-014 SHALL run FSM states IDLE, PULSE, HOLDOFF and WAIT_READY.
REQ-015 SHALL grant in IDLE when pending is non-zero, with priority cold > warm > debug: clear the granted bit, load the counter with LEN-1, set last_grant, and enter PULSE on the next cycle.
REQ-016 SHALL drive exactly the granted *_reset_n low for exactly LEN cycles while in PULSE; all other *_reset_n stay 1.
REQ-017 SHALL make the first low cycle of a pulse the cycle after the grant, giving 2-cycle latency from request edge to reset_n low when IDLE.
REQ-018 SHALL, at the end of PULSE, enter HOLDOFF for HOLDOFF cycles, or go directly to the next state when HOLDOFF = 0.
REQ-019 SHALL, after HOLDOFF, enter WAIT_READY if the grant was cold or warm, otherwise enter IDLE.
REQ-020 SHALL leave WAIT_READY for IDLE on the first cycle with hps_ready = 1; there is no timeout.
REQ-021 SHALL clear all pending bits when cold is granted, including edges arriving in that same cycle.
REQ-022 SHALL latch new edges of any type during PULSE, HOLDOFF and WAIT_READY, except that cold is still cleared per REQ-021 only at grant time.
REQ-023 SHALL merge a repeated edge of an already-pending type into the single pending bit.
REQ-024 SHALL, on simultaneous edges in one cycle, set all corresponding bits and serve them by priority.
REQ-025 SHALL use an 8-bit counter with no wrap; the counter SHALL saturate at 0 outside PULSE and HOLDOFF.

Reset
REQ-026 SHALL, on reset = 1 at a clk edge, set the state to IDLE, pending = 0, last_grant = 0, counter = 0, all *_reset_n = 1 and busy = 0.
REQ-027 SHALL load the edge-history registers with 1 during reset, so a request held high through reset produces no edge.
REQ-028 SHALL abort a pulse in progress when reset asserts mid-pulse, with *_reset_n returning to 1 on the next clock.

Structure
REQ-029 SHALL place the state enum, the grant encoding (0..3) and the default length constants in shared package hps_reset_pkg.
REQ-030 SHALL implement the counter as one sub-module, reset_pulse_timer, with load, value and done (count = 0) signals.
REQ-031 SHALL register all outputs, with no combinational path from inputs to outputs.

Verification
REQ-032 SHALL check that a single req_warm edge, with hps_ready = 1, gives warm_reset_n low for exactly 2 cycles starting 2 cycles after the edge, then busy low after HOLDOFF + 1 cycles, with last_grant = 2.
REQ-033 SHALL check that req_debug and req_warm rising in the same cycle give the warm pulse (2 cycles), then 16 holdoff cycles, then the debug pulse (32 cycles), with pending = 3'b100 during the warm pulse.
REQ-034 SHALL check that req_cold during a debug pulse, with a warm edge also pending, makes the cold pulse (6 cycles) follow the holdoff, clears pending to 0, and never issues the warm pulse.
REQ-035 SHALL check that, after a cold pulse with hps_ready = 0 for 40 cycles, the block stays in WAIT_READY and busy = 1, then returns to IDLE one cycle after hps_ready rises.
REQ-036 SHALL check that asserting reset on the 3rd cycle of the debug pulse returns debug_reset_n to 1 on the next clock, with pending = 0 and no pulse after reset with req_debug held high.
